// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared constants for the rf_bypass_mp register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_NREGS  = 8;
    localparam int RF_NRD    = 2;

    // Bit positions of the individual causes that can set the sticky err flag
    localparam int RF_ERR_NUM        = 3;
    localparam int RF_ERR_RANGE      = 0;
    localparam int RF_ERR_DOUBLE_RSV = 1;
    localparam int RF_ERR_UNRSV_WR   = 2;

    typedef logic [RF_ERR_NUM-1:0] rf_err_vec_t;

endpackage

`default_nettype wire

// File: rtl/rf_rd_port.sv
// ============================================================================
// Module      : rf_rd_port
// Description : One combinational read port: register mux, write bypass and
//               operand-ready logic. Honours RF_ZERO_REG_EN (no bypass of r0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_rd_port
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREGS  = RF_NREGS,
    parameter int SEL_W  = $clog2(NREGS)
) (
    input  logic [SEL_W-1:0]  rd_sel_i,
    input  logic              byp_en_i,
    input  logic              wr_en_i,
    input  logic [SEL_W-1:0]  wr_sel_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] regs_i [NREGS],
    input  logic [NREGS-1:0]  pending_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_ready_o
);

    localparam logic [SEL_W:0] c_NREGS = (SEL_W+1)'(NREGS);

    logic w_in_range;
    logic w_wr_zero;
    logic w_hit;

    assign w_in_range = ({1'b0, rd_sel_i} < c_NREGS);

`ifdef RF_ZERO_REG_EN
    assign w_wr_zero = (wr_sel_i == '0);
`else
    assign w_wr_zero = 1'b0;
`endif

    assign w_hit = wr_en_i & byp_en_i & ~w_wr_zero & (wr_sel_i == rd_sel_i);

    // Out-of-range indices read as zero and are always ready
    always_comb begin
        rd_data_o  = '0;
        rd_ready_o = 1'b1;
        if (w_in_range) begin
            if (w_hit) begin
                rd_data_o  = wr_data_i;
                rd_ready_o = 1'b1;
            end else begin
                rd_data_o  = regs_i[rd_sel_i];
                rd_ready_o = ~pending_i[rd_sel_i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_bypass_mp.sv
// ============================================================================
// Module      : rf_bypass_mp
// Description : Multi-read-port register file with per-port write bypass,
//               pending-write scoreboard and sticky err flag.
//               Optional: RF_ZERO_REG_EN hardwires register 0 to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_bypass_mp
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREGS  = RF_NREGS,
    parameter int NRD    = RF_NRD,
    parameter int SEL_W  = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*SEL_W-1:0]  rd_sel,
    input  logic [NRD-1:0]        rd_byp_en,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_ready,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rsv_en,
    input  logic [SEL_W-1:0]      rsv_sel,
    output logic                  err
);

    localparam logic [SEL_W:0] c_NREGS = (SEL_W+1)'(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  pending_q;
    logic [NREGS-1:0]  pending_d;
    logic              err_q;
    logic              err_d;

    logic        w_wr_in_range;
    logic        w_rsv_in_range;
    logic        w_wr_zero;
    logic        w_rsv_zero;
    logic        w_wr_ok;
    logic        w_rsv_ok;
    rf_err_vec_t w_err_cause;

    assign w_wr_in_range  = ({1'b0, wr_sel}  < c_NREGS);
    assign w_rsv_in_range = ({1'b0, rsv_sel} < c_NREGS);

`ifdef RF_ZERO_REG_EN
    assign w_wr_zero  = (wr_sel  == '0);
    assign w_rsv_zero = (rsv_sel == '0);
`else
    assign w_wr_zero  = 1'b0;
    assign w_rsv_zero = 1'b0;
`endif

    assign w_wr_ok  = wr_en  & w_wr_in_range  & ~w_wr_zero;
    assign w_rsv_ok = rsv_en & w_rsv_in_range & ~w_rsv_zero;

    always_comb begin
        w_err_cause                    = '0;
        w_err_cause[RF_ERR_RANGE]      = (wr_en & ~w_wr_in_range) | (rsv_en & ~w_rsv_in_range);
        w_err_cause[RF_ERR_DOUBLE_RSV] = w_rsv_ok & pending_q[rsv_sel]
                                       & ~(w_wr_ok & (wr_sel == rsv_sel));
        w_err_cause[RF_ERR_UNRSV_WR]   = w_wr_ok & ~pending_q[wr_sel];
    end

    // Reserve is applied after write so a same-index pair leaves pending set
    always_comb begin
        pending_d = pending_q;
        if (w_wr_ok) begin
            pending_d[wr_sel] = 1'b0;
        end
        if (w_rsv_ok) begin
            pending_d[rsv_sel] = 1'b1;
        end
    end

    assign err_d = err_q | (|w_err_cause);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_ok) begin
            regs_q[wr_sel] <= wr_data;
        end
    end

    assign err = err_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd_port
        rf_rd_port #(
            .DATA_W (DATA_W),
            .NREGS  (NREGS),
            .SEL_W  (SEL_W)
        ) u_rd_port (
            .rd_sel_i   (rd_sel[p*SEL_W +: SEL_W]),
            .byp_en_i   (rd_byp_en[p]),
            .wr_en_i    (wr_en),
            .wr_sel_i   (wr_sel),
            .wr_data_i  (wr_data),
            .regs_i     (regs_q),
            .pending_i  (pending_q),
            .rd_data_o  (rd_data[p*DATA_W +: DATA_W]),
            .rd_ready_o (rd_ready[p])
        );
    end

endmodule

`default_nettype wire
